// File: rtl/dco_freq_lock_ctrl.sv
// ----------------------------------------------------------------------------
// dco_freq_lock_ctrl
//
// Coarse frequency-lock controller for the ADPLL phase-accumulator DCO.
// It runs a successive-approximation search over the DCO control code. For
// each trial code the DCO is reset and then run for WINDOW fpga_clk cycles.
// The controller counts DCO rising edges over that window and compares the
// count with the latched target. A bit is kept when count <= target. After
// the last bit it drives the final code, runs the DCO freely and raises
// locked_o for the fine loop.
//
// Ports:
//   fpga_clk_i    system clock (also clocks the DCO)
//   reset_i       asynchronous active-high reset
//   start_i       single-cycle search request, honoured in IDLE or DONE
//   target_cnt_i  desired DCO rising edges per window, latched on start
//   dco_clk_i     DCO output (accumulator MSB), synchronous to fpga_clk_i
//   k_val_o       control code to the DCO (MSB is always 0)
//   dco_en_o      DCO enable
//   dco_rst_o     DCO reset, active-high
//   busy_o        high from the accepted start until DONE
//   locked_o      high in DONE
//   meas_cnt_o    edge count from the most recent completed window
// ----------------------------------------------------------------------------
module dco_freq_lock_ctrl #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 16,
    parameter int WINDOW    = 256
) (
    input  logic                 fpga_clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] target_cnt_i,
    input  logic                 dco_clk_i,
    output logic [WIDTH-1:0]     k_val_o,
    output logic                 dco_en_o,
    output logic                 dco_rst_o,
    output logic                 busy_o,
    output logic                 locked_o,
    output logic [CNT_WIDTH-1:0] meas_cnt_o
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_MEASURE = 3'd2;
    localparam logic [2:0] ST_DECIDE  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // The search never touches the code MSB: keeping the DCO below fclk/2
    // guarantees every DCO edge is visible to the fpga_clk sampler.
    localparam logic [IDX_W-1:0]     IDX_INIT = IDX_W'(WIDTH - 2);
    localparam logic [IDX_W-1:0]     IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [CNT_WIDTH-1:0] WIN_LAST = CNT_WIDTH'(WINDOW - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     K_ZERO   = {WIDTH{1'b0}};

    logic [2:0]           state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [CNT_WIDTH-1:0] target_r;
    logic [CNT_WIDTH-1:0] edge_cnt_r;
    logic [CNT_WIDTH-1:0] win_cnt_r;
    logic                 prev_r;

    logic                 accept_s;
    logic                 rise_s;
    logic                 cnt_sat_s;

    // Start request qualification, rising-edge detect and counter saturation.
    always_comb begin
        accept_s  = 1'b0;
        rise_s    = 1'b0;
        cnt_sat_s = 1'b0;
        if (start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (dco_clk_i && !prev_r) begin
            rise_s = 1'b1;
        end else begin
            rise_s = 1'b0;
        end
        if (edge_cnt_r == CNT_MAX) begin
            cnt_sat_s = 1'b1;
        end else begin
            cnt_sat_s = 1'b0;
        end
    end

    // Search state machine; every output is a register updated here so the
    // DCO sees clean, glitch-free control.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= ST_IDLE;
            idx_r      <= IDX_INIT;
            target_r   <= CNT_ZERO;
            edge_cnt_r <= CNT_ZERO;
            win_cnt_r  <= CNT_ZERO;
            prev_r     <= 1'b0;
            k_val_o    <= K_ZERO;
            dco_en_o   <= 1'b0;
            dco_rst_o  <= 1'b1;
            busy_o     <= 1'b0;
            locked_o   <= 1'b0;
            meas_cnt_o <= CNT_ZERO;
        end else if (accept_s) begin
            // Same path from IDLE and DONE so a restart costs the same cycles.
            state_r   <= ST_SETUP;
            idx_r     <= IDX_INIT;
            target_r  <= target_cnt_i;
            k_val_o   <= K_ZERO;
            dco_en_o  <= 1'b0;
            dco_rst_o <= 1'b1;
            busy_o    <= 1'b1;
            locked_o  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_SETUP: begin
                    // DCO accumulator is cleared by dco_rst_o during this
                    // cycle; the trial bit and run enable take effect as
                    // the window opens.
                    k_val_o[idx_r] <= 1'b1;
                    edge_cnt_r     <= CNT_ZERO;
                    win_cnt_r      <= CNT_ZERO;
                    prev_r         <= 1'b0;
                    dco_rst_o      <= 1'b0;
                    dco_en_o       <= 1'b1;
                    state_r        <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    prev_r <= dco_clk_i;
                    if (rise_s && !cnt_sat_s) begin
                        edge_cnt_r <= edge_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        edge_cnt_r <= edge_cnt_r;
                    end
                    if (win_cnt_r == WIN_LAST) begin
                        state_r <= ST_DECIDE;
                    end else begin
                        win_cnt_r <= win_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_DECIDE: begin
                    meas_cnt_o <= edge_cnt_r;
                    // Equality keeps the bit: result is the largest code
                    // whose count does not exceed the target.
                    if (edge_cnt_r > target_r) begin
                        k_val_o[idx_r] <= 1'b0;
                    end else begin
                        k_val_o[idx_r] <= 1'b1;
                    end
                    if (idx_r == IDX_ZERO) begin
                        state_r  <= ST_DONE;
                        busy_o   <= 1'b0;
                        locked_o <= 1'b1;
                    end else begin
                        idx_r     <= idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                        dco_rst_o <= 1'b1;
                        dco_en_o  <= 1'b0;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    idx_r      <= IDX_INIT;
                    k_val_o    <= K_ZERO;
                    dco_en_o   <= 1'b0;
                    dco_rst_o  <= 1'b1;
                    busy_o     <= 1'b0;
                    locked_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dco_freq_lock_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dco_freq_lock_ctrl
//
// Directed bench for dco_freq_lock_ctrl with a phase-accumulator DCO model
// in the loop (WIDTH=4, WINDOW=256, so code k yields 16*k edges per window).
// ----------------------------------------------------------------------------
module tb_dco_freq_lock_ctrl;

    localparam int WIDTH     = 4;
    localparam int CNT_WIDTH = 16;
    localparam int WINDOW    = 256;
    localparam int LOCK_LAT  = 1 + (WIDTH - 1) * (WINDOW + 2);
    localparam int LIMIT     = 2000;

    logic                 fpga_clk_i;
    logic                 reset_i;
    logic                 start_i;
    logic [CNT_WIDTH-1:0] target_cnt_i;
    logic                 dco_clk_i;
    logic [WIDTH-1:0]     k_val_o;
    logic                 dco_en_o;
    logic                 dco_rst_o;
    logic                 busy_o;
    logic                 locked_o;
    logic [CNT_WIDTH-1:0] meas_cnt_o;

    logic [WIDTH-1:0]     acc_r;
    logic                 msb_seen_r;

    int tests;
    int fails;

    dco_freq_lock_ctrl #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .WINDOW    (WINDOW)
    ) dut (
        .fpga_clk_i   (fpga_clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .target_cnt_i (target_cnt_i),
        .dco_clk_i    (dco_clk_i),
        .k_val_o      (k_val_o),
        .dco_en_o     (dco_en_o),
        .dco_rst_o    (dco_rst_o),
        .busy_o       (busy_o),
        .locked_o     (locked_o),
        .meas_cnt_o   (meas_cnt_o)
    );

    // Clock generation.
    initial begin
        fpga_clk_i = 1'b0;
        forever #5 fpga_clk_i = ~fpga_clk_i;
    end

    // Phase-accumulator DCO model; output is the accumulator MSB.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_r <= 4'd0;
        end else if (dco_rst_o) begin
            acc_r <= 4'd0;
        end else if (dco_en_o) begin
            acc_r <= acc_r + k_val_o;
        end else begin
            acc_r <= acc_r;
        end
    end
    assign dco_clk_i = acc_r[WIDTH-1];

    // Sticky monitor: the code MSB must never be driven high.
    always @(negedge fpga_clk_i) begin
        if (k_val_o[WIDTH-1] === 1'b1) msb_seen_r <= 1'b1;
    end

    task automatic pulse_start(input logic [CNT_WIDTH-1:0] tgt);
        @(negedge fpga_clk_i);
        start_i      = 1'b1;
        target_cnt_i = tgt;
        @(negedge fpga_clk_i);
        start_i      = 1'b0;
    endtask

    // Waits (bounded) for locked_o; cyc counts posedges since the accept edge.
    task automatic wait_lock(input int cyc_in, output int cyc_out);
        int c;
        c = cyc_in;
        while ((locked_o !== 1'b1) && (c < LIMIT)) begin
            @(negedge fpga_clk_i);
            c++;
        end
        cyc_out = c;
    endtask

    task automatic test_reset();
        reset_i      = 1'b1;
        start_i      = 1'b0;
        target_cnt_i = 16'd0;
        repeat (3) @(negedge fpga_clk_i);
        tests++;
        if (k_val_o !== 4'd0 || dco_en_o !== 1'b0 || dco_rst_o !== 1'b1 ||
            busy_o !== 1'b0 || locked_o !== 1'b0 || meas_cnt_o !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: k=%0d en=%b rst=%b busy=%b lock=%b meas=%0d, want 0 0 1 0 0 0",
                     k_val_o, dco_en_o, dco_rst_o, busy_o, locked_o, meas_cnt_o);
        end
        reset_i = 1'b0;
        @(negedge fpga_clk_i);
        tests++;
        if (busy_o !== 1'b0 || locked_o !== 1'b0 || dco_rst_o !== 1'b1) begin
            fails++;
            $display("FAIL idle_hold: busy=%b lock=%b rst=%b, want 0 0 1", busy_o, locked_o, dco_rst_o);
        end
    endtask

    task automatic test_basic();
        int cyc;
        pulse_start(16'd50);
        cyc = 1;
        tests++;
        if (busy_o !== 1'b1 || locked_o !== 1'b0 || k_val_o !== 4'd0) begin
            fails++;
            $display("FAIL basic_accept: busy=%b lock=%b k=%0d, want 1 0 0", busy_o, locked_o, k_val_o);
        end
        while (cyc < 260) begin
            @(negedge fpga_clk_i);
            cyc++;
        end
        // First trial k=4 gave 64 > 50 (cleared), second trial k=2 now set.
        tests++;
        if (meas_cnt_o !== 16'd64 || k_val_o !== 4'd2) begin
            fails++;
            $display("FAIL basic_first_trial: meas=%0d k=%0d, want 64 2", meas_cnt_o, k_val_o);
        end
        wait_lock(cyc, cyc);
        tests++;
        if (cyc !== LOCK_LAT) begin
            fails++;
            $display("FAIL basic_latency: got %0d cycles, want %0d", cyc, LOCK_LAT);
        end
        tests++;
        if (k_val_o !== 4'd3 || meas_cnt_o !== 16'd48) begin
            fails++;
            $display("FAIL basic_result: k=%0d meas=%0d, want 3 48", k_val_o, meas_cnt_o);
        end
        tests++;
        if (busy_o !== 1'b0 || dco_en_o !== 1'b1 || dco_rst_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_done_ctrl: busy=%b en=%b rst=%b, want 0 1 0", busy_o, dco_en_o, dco_rst_o);
        end
    endtask

    task automatic test_search(input logic [CNT_WIDTH-1:0] tgt,
                               input logic [WIDTH-1:0] exp_k,
                               input logic [CNT_WIDTH-1:0] exp_meas);
        int cyc;
        pulse_start(tgt);
        wait_lock(1, cyc);
        tests++;
        if (cyc !== LOCK_LAT || k_val_o !== exp_k || meas_cnt_o !== exp_meas) begin
            fails++;
            $display("FAIL search_t%0d: cyc=%0d k=%0d meas=%0d, want %0d %0d %0d",
                     tgt, cyc, k_val_o, meas_cnt_o, LOCK_LAT, exp_k, exp_meas);
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        pulse_start(16'd50);
        cyc = 1;
        while ((locked_o !== 1'b1) && (cyc < LIMIT)) begin
            @(negedge fpga_clk_i);
            cyc++;
            if (cyc == 100) begin
                start_i      = 1'b1;
                target_cnt_i = 16'hFFFF;
            end else if (cyc == 101) begin
                start_i = 1'b0;
            end else if (cyc == 400) begin
                target_cnt_i = 16'd0;
            end
        end
        tests++;
        if (cyc !== LOCK_LAT || k_val_o !== 4'd3 || meas_cnt_o !== 16'd48) begin
            fails++;
            $display("FAIL ignore_start: cyc=%0d k=%0d meas=%0d, want %0d 3 48",
                     cyc, k_val_o, meas_cnt_o, LOCK_LAT);
        end
    endtask

    task automatic test_restart();
        int cyc;
        pulse_start(16'd100);
        tests++;
        if (locked_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL restart_drop: lock=%b busy=%b, want 0 1", locked_o, busy_o);
        end
        wait_lock(1, cyc);
        // k=4 -> 64 keep, k=6 -> 96 keep, k=7 -> 112 clear.
        tests++;
        if (cyc !== LOCK_LAT || k_val_o !== 4'd6 || meas_cnt_o !== 16'd112) begin
            fails++;
            $display("FAIL restart_result: cyc=%0d k=%0d meas=%0d, want %0d 6 112",
                     cyc, k_val_o, meas_cnt_o, LOCK_LAT);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(16'd50);
        repeat (399) @(negedge fpga_clk_i);
        tests++;
        if (busy_o !== 1'b1 || k_val_o !== 4'd2 || dco_rst_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_measure: busy=%b k=%0d rst=%b, want 1 2 0", busy_o, k_val_o, dco_rst_o);
        end
        reset_i = 1'b1;
        #1;
        tests++;
        if (dco_rst_o !== 1'b1 || k_val_o !== 4'd0 || busy_o !== 1'b0 || dco_en_o !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: rst=%b k=%0d busy=%b en=%b, want 1 0 0 0",
                     dco_rst_o, k_val_o, busy_o, dco_en_o);
        end
        @(negedge fpga_clk_i);
        reset_i = 1'b0;
        test_search(16'd50, 4'd3, 16'd48);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        msb_seen_r = 1'b0;
        test_reset();
        test_basic();
        test_search(16'd0, 4'd0, 16'd16);
        test_search(16'hFFFF, 4'd7, 16'd112);
        test_search(16'd64, 4'd4, 16'd80);
        test_ignore_start();
        test_restart();
        test_reset_mid();
        tests++;
        if (msb_seen_r !== 1'b0) begin
            fails++;
            $display("FAIL code_msb: k_val_o[3] seen %b, want 0", msb_seen_r);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
